// File: rtl/sobel_pkg.sv
// Shared constants and state type for the Sobel edge-detection stage.
package sobel_pkg;

  localparam int PIXEL_WIDTH_OUT = 8;
  localparam int SOBEL_WINDOW    = 9;
  localparam int GRAD_WIDTH      = 11;
  localparam int MAG_WIDTH       = 12;
  localparam int CNT_WIDTH       = 4;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DONE    = 2'd3
  } sobel_state_e;

endpackage : sobel_pkg

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel operator: Gx/Gy gradients, |Gx|+|Gy|, clamp to 8 bits.
module sobel_kernel
  import sobel_pkg::*;
(
  input  logic [SOBEL_WINDOW-1:0][PIXEL_WIDTH_OUT-1:0] win_i,
  output logic [PIXEL_WIDTH_OUT-1:0]                   mag_o
);

  function automatic logic signed [GRAD_WIDTH-1:0] zext(input logic [PIXEL_WIDTH_OUT-1:0] p);
    return signed'({{(GRAD_WIDTH-PIXEL_WIDTH_OUT){1'b0}}, p});
  endfunction

  function automatic logic [GRAD_WIDTH-1:0] abs_grad(input logic signed [GRAD_WIDTH-1:0] v);
    logic [GRAD_WIDTH-1:0] r;
    if (v[GRAD_WIDTH-1]) begin
      r = -v;
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic signed [GRAD_WIDTH-1:0] gx_s;
  logic signed [GRAD_WIDTH-1:0] gy_s;
  logic        [MAG_WIDTH-1:0]  mag_s;

  // Gradients, magnitude and saturation.
  always_comb begin
    gx_s  = (zext(win_i[2]) + (zext(win_i[5]) <<< 1) + zext(win_i[8]))
          - (zext(win_i[0]) + (zext(win_i[3]) <<< 1) + zext(win_i[6]));
    gy_s  = (zext(win_i[6]) + (zext(win_i[7]) <<< 1) + zext(win_i[8]))
          - (zext(win_i[0]) + (zext(win_i[1]) <<< 1) + zext(win_i[2]));
    mag_s = {1'b0, abs_grad(gx_s)} + {1'b0, abs_grad(gy_s)};
    if (mag_s > 12'd255) begin
      mag_o = 8'hFF;
    end else begin
      mag_o = mag_s[PIXEL_WIDTH_OUT-1:0];
    end
  end

endmodule : sobel_kernel

// File: rtl/sobel_core.sv
// Streaming Sobel stage: gathers a 3x3 raster window, emits one edge pixel per window.
module sobel_core
  import sobel_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       nreset_i,
  input  logic                       start_i,
  input  logic                       in_px_valid_i,
  input  logic [PIXEL_WIDTH_OUT-1:0] in_px_gray_i,
  output logic                       in_ready_o,
  output logic [PIXEL_WIDTH_OUT-1:0] out_px_sobel_o,
  output logic                       out_valid_o
);

  sobel_state_e state_r;
  sobel_state_e next_state_s;
  logic [CNT_WIDTH-1:0]                       cnt_r;
  logic [SOBEL_WINDOW-1:0][PIXEL_WIDTH_OUT-1:0] win_r;
  logic [PIXEL_WIDTH_OUT-1:0]                 kernel_mag_s;
  logic                                       accept_s;
  logic                                       in_ready_r;
  logic                                       out_valid_r;
  logic [PIXEL_WIDTH_OUT-1:0]                 out_px_r;

  // Abort (start_i low) wins over a pixel offered on the same edge.
  assign accept_s = (state_r == ST_LOAD) && start_i && in_px_valid_i;

  // State register.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (start_i) next_state_s = ST_LOAD;
        else         next_state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (!start_i)                              next_state_s = ST_IDLE;
        else if (accept_s && (cnt_r == LAST_IDX))  next_state_s = ST_COMPUTE;
        else                                       next_state_s = ST_LOAD;
      end
      ST_COMPUTE: next_state_s = ST_DONE;
      ST_DONE: begin
        if (start_i) next_state_s = ST_LOAD;
        else         next_state_s = ST_IDLE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Window fill; the counter restarts whenever the next state is not LOAD.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      cnt_r <= 4'd0;
      win_r <= '0;
    end else if (accept_s) begin
      win_r[cnt_r] <= in_px_gray_i;
      cnt_r        <= cnt_r + 4'd1;
    end else if (next_state_s != ST_LOAD) begin
      cnt_r <= 4'd0;
    end
  end

  sobel_kernel u_kernel (
    .win_i (win_r),
    .mag_o (kernel_mag_s)
  );

  // Registered handshake, strobe and result.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_px_r    <= 8'd0;
    end else begin
      in_ready_r  <= (next_state_s == ST_LOAD);
      out_valid_r <= (next_state_s == ST_DONE);
      if (state_r == ST_COMPUTE) begin
        out_px_r <= kernel_mag_s;
      end
    end
  end

  assign in_ready_o     = in_ready_r;
  assign out_valid_o    = out_valid_r;
  assign out_px_sobel_o = out_px_r;

endmodule : sobel_core

// File: tb/tb_sobel_core.sv
// Randomized self-checking bench for sobel_core against a convolution reference model.
module tb_sobel_core;

  logic       clk_i = 1'b0;
  logic       nreset_i;
  logic       start_i;
  logic       in_px_valid_i;
  logic [7:0] in_px_gray_i;
  logic       in_ready_o;
  logic [7:0] out_px_sobel_o;
  logic       out_valid_o;

  int checks_total = 0;
  int checks_pass  = 0;
  int cyc = 0;
  int strobes[$];

  sobel_core dut (
    .clk_i          (clk_i),
    .nreset_i       (nreset_i),
    .start_i        (start_i),
    .in_px_valid_i  (in_px_valid_i),
    .in_px_gray_i   (in_px_gray_i),
    .in_ready_o     (in_ready_o),
    .out_px_sobel_o (out_px_sobel_o),
    .out_valid_o    (out_valid_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) if (out_valid_o) strobes.push_back(cyc);

  task automatic check(input string tag, input int obs, input int exp);
    checks_total++;
    if (obs == exp) checks_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: 3x3 correlation with the Sobel kernels, then |Gx|+|Gy| clamped to 255.
  function automatic int sobel_ref(input int w[9]);
    int kx[9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    int ky[9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    int gx = 0;
    int gy = 0;
    int m;
    for (int i = 0; i < 9; i++) begin
      gx += kx[i] * w[i];
      gy += ky[i] * w[i];
    end
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_px(input int px);
    int t = 0;
    in_px_valid_i = 1'b1;
    in_px_gray_i  = px[7:0];
    while (!in_ready_o && t < 50) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 50) check("ready_timeout", 0, 1);
    @(negedge clk_i);
    in_px_valid_i = 1'b0;
  endtask

  task automatic send_pixels(input int w[9], input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 3);
        for (int j = 0; j < g; j++) @(negedge clk_i);
      end
      send_px(w[i]);
    end
  endtask

  task automatic send_window(input string tag, input int w[9], input bit gaps);
    int exp = sobel_ref(w);
    send_pixels(w, 9, gaps);
    check({tag, "_compute_novalid"}, int'(out_valid_o), 0);
    @(negedge clk_i);
    check({tag, "_strobe"}, int'(out_valid_o), 1);
    check({tag, "_px"}, int'(out_px_sobel_o), exp);
    @(negedge clk_i);
    check({tag, "_strobe_off"}, int'(out_valid_o), 0);
    check({tag, "_held"}, int'(out_px_sobel_o), exp);
  endtask

  int flat[9]  = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
  int vert[9]  = '{0, 50, 10, 0, 50, 10, 0, 50, 10};
  int horz[9]  = '{20, 20, 20, 0, 0, 0, 0, 0, 0};
  int satx[9]  = '{0, 128, 255, 0, 128, 255, 0, 128, 255};
  int corn[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 255};
  int rnd[9];
  int n0;

  initial begin
    nreset_i      = 1'b0;
    start_i       = 1'b0;
    in_px_valid_i = 1'b0;
    in_px_gray_i  = 8'd0;
    repeat (3) @(negedge clk_i);
    check("rst_ready", int'(in_ready_o), 0);
    check("rst_valid", int'(out_valid_o), 0);
    check("rst_px", int'(out_px_sobel_o), 0);
    nreset_i = 1'b1;
    @(negedge clk_i);
    check("idle_ready", int'(in_ready_o), 0);
    start_i = 1'b1;
    @(negedge clk_i);
    check("load_ready", int'(in_ready_o), 1);

    send_window("flat", flat, 1'b0);
    send_window("vert", vert, 1'b0);
    send_window("horz", horz, 1'b0);
    send_window("satx", satx, 1'b0);
    send_window("corner", corn, 1'b0);
    send_window("vert_gaps", vert, 1'b1);

    // Abort after 5 pixels, with a pixel offered on the aborting edge.
    n0 = strobes.size();
    send_pixels(horz, 5, 1'b0);
    start_i       = 1'b0;
    in_px_valid_i = 1'b1;
    in_px_gray_i  = 8'd99;
    @(negedge clk_i);
    in_px_valid_i = 1'b0;
    check("abort_ready", int'(in_ready_o), 0);
    repeat (4) @(negedge clk_i);
    check("abort_nostrobe", strobes.size(), n0);
    check("abort_held", int'(out_px_sobel_o), sobel_ref(vert));
    start_i = 1'b1;
    @(negedge clk_i);
    send_window("vert_after_abort", vert, 1'b0);

    // Asynchronous reset mid-window.
    send_pixels(flat, 6, 1'b0);
    #2 nreset_i = 1'b0;
    #1;
    check("mid_rst_px", int'(out_px_sobel_o), 0);
    check("mid_rst_ready", int'(in_ready_o), 0);
    check("mid_rst_valid", int'(out_valid_o), 0);
    @(negedge clk_i);
    nreset_i = 1'b1;
    @(negedge clk_i);
    send_window("horz_after_rst", horz, 1'b0);

    // Back-to-back windows: strobes exactly 11 cycles apart.
    n0 = strobes.size();
    send_window("b2b_a", vert, 1'b0);
    send_window("b2b_b", horz, 1'b0);
    check("b2b_count", strobes.size() - n0, 2);
    if (strobes.size() - n0 == 2) check("b2b_spacing", strobes[n0+1] - strobes[n0], 11);

    // Random windows, some with gaps and extreme pixel values.
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 9; i++) begin
        case ($urandom_range(0, 3))
          0: rnd[i] = 0;
          1: rnd[i] = 255;
          default: rnd[i] = $urandom_range(0, 255);
        endcase
      end
      send_window($sformatf("rnd%0d", k), rnd, k[0]);
    end

    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule : tb_sobel_core

// File: doc/sobel_core.md
# sobel_core

Streaming Sobel edge-detection stage sitting directly downstream of the grayscale converter. It accepts 8-bit gray pixels one per handshake and collects them into a 3x3 window in raster order (top row first, left to right). It then computes the horizontal and vertical Sobel gradients, forms the saturated magnitude |Gx|+|Gy|, and presents one 8-bit edge pixel per window with a single-cycle valid strobe.

## Interface
- PIXEL_WIDTH_OUT, 8: gray input width and edge output width (shared constant).
- SOBEL_WINDOW, 9: pixels per window (3x3); fixed, not intended for override.
- GRAD_WIDTH, 11: signed width of Gx/Gy, covering ±1020.
- clk_i  input  1  clock; all state updates on the rising edge.
- nreset_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  level enable; high = process windows, low = abort/idle.
- in_px_valid_i  input  1  in_px_gray_i holds a valid pixel.
- in_px_gray_i  input  PIXEL_WIDTH_OUT  gray pixel, unsigned.
- in_ready_o  output  1  block can accept a pixel; high only in LOAD.
- out_px_sobel_o  output  PIXEL_WIDTH_OUT  edge magnitude, registered, held between windows.
- out_valid_o  output  1  one-cycle strobe; out_px_sobel_o is new this cycle.

## Operation
- States: IDLE, LOAD, COMPUTE, DONE.
- IDLE: the counter is held at 0. start_i=1 -> LOAD; otherwise stay.
- LOAD:
  - A pixel is accepted on an edge where in_px_valid_i && in_ready_o.
  - It is stored at window index cnt (0..8) and cnt increments.
  - in_px_valid_i gaps are allowed; cnt holds during a gap.
  - Acceptance of index 8 -> COMPUTE.
  - start_i=0 in LOAD -> IDLE: the partial window is discarded, cnt=0, and no strobe is produced. The discarding takes priority even if a pixel is valid on that edge.
- COMPUTE:
  - Window indices: p0 p1 p2 / p3 p4 p5 / p6 p7 p8.
  - Gx = (p2+2p5+p8)-(p0+2p3+p6).
  - Gy = (p6+2p7+p8)-(p0+2p1+p2).
  - Operands are zero-extended to GRAD_WIDTH and subtracted in signed arithmetic.
  - mag = |Gx|+|Gy| in 12 bits unsigned (max 2040).
  - out = mag>255 ? 255 : mag[7:0].
  - The result is registered into out_px_sobel_o on the COMPUTE->DONE edge. COMPUTE always moves to DONE, regardless of start_i.
- DONE:
  - out_valid_o=1 for exactly this cycle.
  - Next state: start_i=1 -> LOAD with cnt=0 (a new, non-overlapping window); start_i=0 -> IDLE.
- In COMPUTE and DONE, in_ready_o=0 and input pixels are ignored.
- Illegal state encoding -> IDLE.
- out_px_sobel_o changes only on the COMPUTE->DONE edge or on reset.

## Timing
- Reset values: state IDLE, cnt 0, window registers 0, out_px_sobel_o 0, out_valid_o 0, in_ready_o 0.
- Reset is asynchronous and applies immediately, including mid-window; the partial window is lost.
- in_ready_o rises the cycle after the edge that samples start_i=1 in IDLE.
- Latency: 9th pixel accepted at edge k -> COMPUTE during cycle k+1. At edge k+1, out_px_sobel_o is updated and out_valid_o=1 from edge k+1 until edge k+2.
- Minimum period per window: 11 cycles (9 LOAD + COMPUTE + DONE) with back-to-back valid pixels.
- out_valid_o is registered: it is asserted with the state entering DONE and never glitches combinationally.

## Structure
- Add SOBEL_WINDOW, GRAD_WIDTH and the sobel state enum typedef to parameters.svh next to PIXEL_WIDTH_OUT.
- One combinational sub-module, sobel_kernel:
  - Inputs: nine PIXEL_WIDTH_OUT pixels.
  - Output: a saturated PIXEL_WIDTH_OUT magnitude.
  - It contains the Gx/Gy adders, the absolute values and the clamp.
- sobel_core holds the FSM, counter, window registers and output register.

## Test plan
- Flat window, all nine pixels = 100 -> out_px_sobel_o=0, out_valid_o high for one cycle, 2 cycles after the 9th accept.
- Vertical edge, columns 0 / 50 / 10 in every row -> Gx=40, Gy=0 -> output 40.
- Horizontal edge, top row 20, other rows 0 -> Gy=-80, Gx=0 -> output 80.
- Saturation, left column 0 and right column 255 (Gx=1020) -> output 255. Also all-zero except p8=255 -> |Gx|+|Gy|=510 -> output 255.
- Random in_px_valid_i gaps within a window -> same result as the gapless case. start_i dropped after 5 pixels -> IDLE, no strobe, output held. A following full window of the vertical-edge case -> 40.
- nreset_i asserted after 6 pixels -> all outputs 0 immediately. After release with start_i=1, a full window of the horizontal-edge case -> 80. Two consecutive windows with start_i held high -> strobes spaced exactly 11 cycles apart.
